// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters and the round-robin arbiter.
// The arbiter takes the slave modport; the requester/FIFO side takes master.
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  wfull;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  busy;

  modport master (
    output req, req_data, wfull,
    input  grant, ack, winc, wdata, busy
  );

  modport slave (
    input  req, req_data, wfull,
    output grant, ack, winc, wdata, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Each grant lasts at most MAXBURST accepted writes; wfull stalls without timeout.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input  logic            wclk,
  input  logic            wrst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAXBURST) + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]      r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_grant;

  logic             w_own_req;
  logic             w_winc;
  logic             w_rel;
  logic             w_arb;
  logic             w_found;
  logic [OW-1:0]    w_win;
  logic [NREQ-1:0]  w_win_oh;
  logic [DSIZE-1:0] w_wdata;
  int               w_idx;

  assign w_own_req = bus.req[r_owner];
  assign w_winc    = (r_state == S_GRANT) & w_own_req & ~bus.wfull;
  assign w_rel     = ~w_own_req |
                     (w_winc & (r_cnt == CW'(MAXBURST - 1)));
  assign w_arb     = (r_state == S_IDLE) | w_rel;
  assign w_win_oh  = NREQ'(1) << w_win;

  // Scan downward so the nearest requester after r_last is written last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % NREQ;
      if (bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = OW'(w_idx);
      end
    end
  end

  always_comb begin
    w_wdata = '0;
    if (r_state == S_GRANT)
      w_wdata = bus.req_data[int'(r_owner)*DSIZE +: DSIZE];
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= OW'(NREQ - 1);
      r_cnt   <= '0;
      r_grant <= '0;
    end else if (w_arb) begin
      if (w_found) begin
        r_state <= S_GRANT;
        r_owner <= w_win;
        r_last  <= w_win;
        r_cnt   <= '0;
        r_grant <= w_win_oh;
      end else begin
        r_state <= S_IDLE;
        r_grant <= '0;
      end
    end else if (w_winc && (r_cnt < CW'(MAXBURST))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign bus.grant = r_grant;
  assign bus.ack   = r_grant & {NREQ{w_winc}};
  assign bus.winc  = w_winc;
  assign bus.wdata = w_wdata;
  assign bus.busy  = (r_state == S_GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios then random traffic,
// all checked against a round-robin reference model.
module tb_fifo_wr_arbiter;
  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBURST = 4;

  logic wclk;
  logic wrst_n;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)
  ) dut (
    .wclk(wclk),
    .wrst_n(wrst_n),
    .bus(bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;

  // model: m_own = -1 when nobody owns the port
  int m_own;
  int m_last;
  int m_writes;

  logic [NREQ-1:0] s_grant;
  logic            s_winc;
  int              n_w;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_winc();
    return (m_own >= 0) && bus.req[m_own] && !bus.wfull;
  endfunction

  task automatic m_reset();
    m_own    = -1;
    m_last   = NREQ - 1;
    m_writes = 0;
  endtask

  task automatic m_step();
    bit w;
    int win;
    w = m_winc();
    if (m_own < 0 || !bus.req[m_own] ||
        (w && m_writes == MAXBURST - 1)) begin
      win = -1;
      for (int k = 1; k <= NREQ; k++)
        if (win < 0 && bus.req[(m_last + k) % NREQ])
          win = (m_last + k) % NREQ;
      if (win >= 0) begin
        m_own    = win;
        m_last   = win;
        m_writes = 0;
      end else begin
        m_own = -1;
      end
    end else if (w) begin
      m_writes++;
    end
  endtask

  task automatic tick();
    logic [NREQ-1:0]  e_grant;
    logic [DSIZE-1:0] e_data;
    @(negedge wclk);
    e_grant = (m_own >= 0) ? NREQ'(1) << m_own : '0;
    e_data  = (m_own >= 0) ? bus.req_data[m_own*DSIZE +: DSIZE] : '0;
    s_grant = bus.grant;
    s_winc  = bus.winc;
    chk("grant", 32'(bus.grant), 32'(e_grant));
    chk("ack",   32'(bus.ack),   32'(m_winc() ? e_grant : '0));
    chk("winc",  32'(bus.winc),  32'(m_winc()));
    chk("wdata", 32'(bus.wdata), 32'(e_data));
    chk("busy",  32'(bus.busy),  32'(m_own >= 0));
    m_step();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_winc",  32'(bus.winc),  32'h0);
    chk("rst_ack",   32'(bus.ack),   32'h0);
    chk("rst_wdata", 32'(bus.wdata), 32'h0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n       = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.wfull    = 1'b0;
    m_reset();
    @(posedge wclk);
    #1;

    // single requester 2, burst of 4 then regrant
    do_reset();
    bus.req      = 4'b0100;
    bus.req_data = 32'h00A5_0000;
    tick();
    n_w = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_winc) n_w++;
    end
    chk("t1_grant", 32'(s_grant), 32'h4);
    chk("t1_writes", 32'(n_w), 32'd6);
    bus.req = '0;
    tick();

    // all four requesting: 0,1,2,3,0 with no bubbles
    do_reset();
    bus.req      = 4'b1111;
    bus.req_data = 32'h4433_2211;
    tick();
    n_w = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_winc) n_w++;
      if (i % 4 == 0)
        chk("t2_rr", 32'(s_grant), 32'(1 << ((i / 4) % 4)));
    end
    chk("t2_writes", 32'(n_w), 32'd20);

    // wfull stall with requester 1 at count 2
    do_reset();
    bus.req      = 4'b0010;
    bus.req_data = 32'h0000_5A00;
    tick();
    tick();
    tick();
    bus.wfull = 1'b1;
    bus.req   = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_stall_winc", 32'(s_winc), 32'h0);
      chk("t3_stall_grant", 32'(s_grant), 32'h2);
    end
    bus.wfull = 1'b0;
    n_w = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (s_winc) n_w++;
    end
    chk("t3_writes", 32'(n_w), 32'd2);
    tick();
    chk("t3_handover", 32'(s_grant), 32'h1);

    // owner 3 drops after one ack
    do_reset();
    bus.req      = 4'b1000;
    bus.req_data = 32'h3C00_0011;
    tick();
    tick();
    chk("t4_first", 32'(s_winc), 32'h1);
    bus.req = 4'b0001;
    tick();
    chk("t4_drop_winc", 32'(s_winc), 32'h0);
    tick();
    chk("t4_next", 32'(s_grant), 32'h1);

    // async reset mid-burst
    do_reset();
    bus.req      = 4'b0100;
    bus.req_data = 32'h0077_0000;
    tick();
    tick();
    chk("t5_pre", 32'(s_grant), 32'h4);
    wrst_n = 1'b0;
    #1;
    m_reset();
    chk("t5_grant", 32'(bus.grant), 32'h0);
    chk("t5_busy",  32'(bus.busy),  32'h0);
    chk("t5_winc",  32'(bus.winc),  32'h0);
    chk("t5_ack",   32'(bus.ack),   32'h0);
    @(posedge wclk);
    #1;
    bus.req = 4'b1100;
    wrst_n  = 1'b1;
    tick();
    tick();
    chk("t5_after", 32'(s_grant), 32'h4);

    // single requester 0 streams continuously
    do_reset();
    bus.req      = 4'b0001;
    bus.req_data = 32'h0000_00C3;
    tick();
    n_w = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_winc) n_w++;
    end
    chk("t6_writes", 32'(n_w), 32'd10);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.req      = NREQ'($urandom);
      bus.req_data = $urandom;
      bus.wfull    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the async FIFO write domain. It shares one FIFO write port (winc/wdata, gated by wfull) among NREQ requesters. Each grant is held for a burst of at most MAXBURST accepted writes. The block sits in the wclk domain directly in front of the write-pointer/full logic and the memory write port.

## Interface
- NREQ, 4: number of requesters, ≥2.
- DSIZE, 8: data width per requester.
- MAXBURST, 4: maximum accepted writes per grant, ≥1.
- wclk  in  1  write-domain clock, rising edge.
- wrst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester write request, level; data is valid while high.
- req_data  in  NREQ*DSIZE  flattened data; requester i occupies bits [i*DSIZE +: DSIZE].
- wfull  in  1  registered FIFO full flag from the write-pointer logic.
- grant  out  NREQ  registered one-hot current owner; all-zero when idle.
- ack  out  NREQ  one-hot pulse; the owner's word is accepted this cycle.
- winc  out  1  FIFO write enable.
- wdata  out  DSIZE  FIFO write data: the owner's req_data slice.
- busy  out  1  registered; high while a grant is held.

## Operation
- Registered state:
  - state: IDLE or GRANT.
  - owner index: ceil(log2 NREQ) bits.
  - last-owner pointer for round-robin.
  - burst count: ceil(log2 MAXBURST)+1 bits, saturating at MAXBURST, never wraps.
- Combinational outputs:
  - winc = (state==GRANT) & req[owner] & ~wfull.
  - ack = onehot(owner) & {NREQ{winc}}.
  - wdata = owner slice when state==GRANT, else 0.
- Release condition, evaluated in GRANT:
  - req[owner]==0 (owner withdrew), or
  - winc & (count==MAXBURST-1) (burst exhausted on this write).
- Arbitration happens at a clock edge when state==IDLE, or when state==GRANT and the release condition holds.
  - Search req from (last_owner+1) mod NREQ upward, wrapping.
  - The previous owner is therefore lowest priority. It is regranted only if no other requester is pending and its req is still high.
  - Winner found: state=GRANT, grant=onehot(winner), last_owner=winner, count=0.
  - No request: state=IDLE, grant=0. last_owner keeps the old value.
- In GRANT without release: count increments on each winc. Grant and owner hold.
- wfull=1: no winc and no ack. Count holds and grant holds with no timeout. Other requesters wait.
- Non-owner req changes have no effect until the next arbitration edge.
- Requester i keeps req and its data stable until it sees ack[i]. It may drop req after any ack. Dropping req without an ack abandons the word; no write occurs.

## Timing
- Reset, asynchronous:
  - state=IDLE, grant=0, busy=0, count=0.
  - last_owner=NREQ-1, so requester 0 has first priority.
  - Outputs winc=0, ack=0, wdata=0 follow combinationally.
  - Reset asserted mid-burst aborts immediately. Writes already accepted stay in the FIFO.
- Grant latency from IDLE: req rises in cycle n → grant and busy in cycle n+1 → first winc/ack in cycle n+1 if wfull=0.
- Back-to-back handover: release at edge n+1 with another requester pending gives a new grant in cycle n+1. No idle bubble.
- Owner drops req: that cycle has no winc. Handover takes effect on the next edge.
- Sustained throughput is one write per cycle while wfull=0.
- wfull is sampled in the same cycle. Because wfull is registered upstream, winc never coincides with wfull=1.

## Test plan
Parameters for all scenarios: NREQ=4, DSIZE=8, MAXBURST=4.
- Reset, then req=4'b0100 with data 8'hA5 held → grant=4'b0100 one cycle after req. winc/ack for 4 consecutive cycles with wdata=8'hA5. Grant then re-issues to requester 2 with count=0.
- req=4'b1111 held constantly → grants follow 0,1,2,3,0. Exactly 4 acks per grant, no idle cycles between grants, 20 writes in 20 cycles after the first grant.
- Requester 1 owns the grant with count=2; force wfull=1 for 5 cycles → winc=0, ack=0, grant holds 4'b0010. After wfull falls, exactly 2 more writes, then handover.
- Owner 3 drops req after 1 ack while req[0]=1 → winc=0 in the drop cycle; grant=4'b0001 on the next edge.
- Assert wrst_n=0 mid-burst with grant=4'b0100 → grant, busy, winc and ack go to 0 without a clock edge. After release with req=4'b1100, first grant goes to requester 2.
- Single requester 0 held for 10 cycles with wfull=0 → continuous winc. Re-arbitration every 4 writes regrants requester 0 with no bubble.
